// File: rtl/asip_fetch_pkg.sv
// ============================================================
// asip_fetch_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ============================================================
`default_nettype none

package asip_fetch_pkg;

  localparam int OPW = 5;
  localparam logic [OPW-1:0] HALT_OPCODE = 5'b11111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================
// fetch_pc_gen : fetch-address / PC registers, redirect mux and incrementer
// Rev 1.0
// ============================================================
`default_nettype none

module fetch_pc_gen #(
  parameter int             AW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          redirect,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] fa_q,
  output logic [AW-1:0] pc_q
);

  logic [AW-1:0] base;
  logic [AW-1:0] base_inc;

  // Incrementer wraps naturally modulo 2^AW.
  assign base     = redirect ? target : fa_q;
  assign base_inc = base + AW'(1);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      fa_q <= RESET_PC;
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= base;
      fa_q <= base_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================
// fetch_unit : instruction-fetch stage (stall, redirect, HALT)
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
// Rev 1.0
// ============================================================
`default_nettype none

module fetch_unit #(
  parameter int             AW       = 16,
  parameter int             IW       = 32,
  parameter int             OPW      = 5,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [AW-1:0] branch_target_i,
  output logic [AW-1:0] imem_addr_o,
  output logic          imem_en_o,
  input  logic [IW-1:0] imem_rdata_i,
  output logic [AW-1:0] pc_o,
  output logic [IW-1:0] instr_o,
  output logic          valid_o,
  output logic          halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched_o,
  output logic [31:0]   perf_stall_o
`endif
);

  import asip_fetch_pkg::*;

  localparam logic [OPW-1:0] HALT_OP = OPW'(HALT_OPCODE);

  fetch_state_t  state;
  logic          valid_q;
  logic [AW-1:0] fa_q;
  logic [AW-1:0] pc_q;
  logic          in_run;
  logic          halt_det;
  logic          load;
  logic          redirect;

  assign in_run   = (state == RUN);
  assign halt_det = valid_q && (imem_rdata_i[IW-1 -: OPW] == HALT_OP);
  assign redirect = in_run && flush_i;
  assign load     = (state == BOOT) || (in_run && (flush_i || (!stall_i && !halt_det)));

  fetch_pc_gen #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .redirect (redirect),
    .target   (branch_target_i),
    .fa_q     (fa_q),
    .pc_q     (pc_q)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      valid_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          valid_q <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (flush_i) begin
            valid_q <= 1'b1;
          end else if (stall_i) begin
            valid_q <= valid_q;
          end else if (halt_det) begin
            valid_q <= 1'b0;
            state   <= HALT;
          end else begin
            valid_q <= 1'b1;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= BOOT;
        end
      endcase
    end
  end

  // Reset is folded in so BOOT's forced enable does not leak out during reset.
  assign imem_en_o   = !reset && ((state == BOOT) || (in_run && (!stall_i || flush_i)));
  assign imem_addr_o = flush_i ? branch_target_i : fa_q;
  assign pc_o        = pc_q;
  assign instr_o     = imem_rdata_i;
  assign valid_o     = valid_q;
  assign halted_o    = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (load && (perf_fetched_o != 32'hFFFF_FFFF))
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (in_run && stall_i && !flush_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
